// File: rtl/pipe_skid_reg_pkg.sv
// rtl/pipe_skid_reg_pkg.sv - shared state encoding and depth constants for the skid register
package pipe_pkg;

  localparam int SKID_DEPTH = 2;
  localparam int CNT_W      = $clog2(SKID_DEPTH + 1);

  typedef enum logic [1:0] {
    S_EMPTY = 2'd0,
    S_BUSY  = 2'd1,
    S_FULL  = 2'd2
  } skid_state_t;

  // Occupancy implied by a state; the unused encoding reads as empty.
  function automatic logic [CNT_W-1:0] state_count(skid_state_t s);
    case (s)
      S_BUSY:  return CNT_W'(1);
      S_FULL:  return CNT_W'(SKID_DEPTH);
      default: return '0;
    endcase
  endfunction

endpackage

// File: rtl/pipe_skid_reg_if.sv
// rtl/pipe_skid_reg_if.sv - ready/valid word stream between pipeline stages
interface pipe_skid_reg_if #(
  parameter int REG_SIZE = 32
);

  logic                valid;
  logic                ready;
  logic [REG_SIZE-1:0] data;

  modport master (output valid, output data, input ready);
  modport slave  (input valid, input data, output ready);

endinterface

// File: rtl/pipe_skid_reg_data_reg.sv
// rtl/pipe_skid_reg_data_reg.sv - enable-loaded data register cleared by reset
module skid_data_reg #(
  parameter int REG_SIZE = 32
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                en,
  input  logic [REG_SIZE-1:0] d,
  output logic [REG_SIZE-1:0] q
);

  // Load on enable, clear asynchronously on reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      q <= '0;
    else if (en)
      q <= d;
  end

endmodule

// File: rtl/pipe_skid_reg.sv
// rtl/pipe_skid_reg.sv - two-entry ready/valid pipeline register with skid entry
module pipe_skid_reg
  import pipe_pkg::*;
#(
  parameter int REG_SIZE = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  flush,
  pipe_skid_reg_if.slave        up,
  pipe_skid_reg_if.master       dn,
  output logic [CNT_W-1:0]      count
);

  skid_state_t         state;
  logic                in_fire;
  logic                out_fire;
  logic                main_en;
  logic                skid_en;
  logic [REG_SIZE-1:0] main_d;
  logic [REG_SIZE-1:0] main_q;
  logic [REG_SIZE-1:0] skid_q;

  // Handshake outputs decode only the state, so neither side sees a path from the other.
  assign up.ready = (state == S_EMPTY) || (state == S_BUSY);
  assign dn.valid = (state == S_BUSY) || (state == S_FULL);
  assign dn.data  = main_q;
  assign count    = state_count(state);

  assign in_fire  = up.valid & up.ready;
  assign out_fire = dn.valid & dn.ready;

  // Main takes the new word when it is (or becomes) the oldest; in FULL it refills from skid.
  assign main_en = !flush && (((state == S_EMPTY) && in_fire) ||
                              ((state == S_BUSY) && in_fire && out_fire) ||
                              ((state == S_FULL) && out_fire));
  assign skid_en = !flush && (state == S_BUSY) && in_fire && !out_fire;
  assign main_d  = (state == S_FULL) ? skid_q : up.data;

  // Occupancy FSM; flush empties it, the unused encoding falls back to empty.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= S_EMPTY;
    end else if (flush) begin
      state <= S_EMPTY;
    end else begin
      case (state)
        S_EMPTY: if (in_fire) state <= S_BUSY;
        S_BUSY: begin
          if (in_fire && !out_fire)
            state <= S_FULL;
          else if (!in_fire && out_fire)
            state <= S_EMPTY;
        end
        S_FULL:  if (out_fire) state <= S_BUSY;
        default: state <= S_EMPTY;
      endcase
    end
  end

  skid_data_reg #(.REG_SIZE(REG_SIZE)) u_main (
    .clk (clk),
    .rst (rst),
    .en  (main_en),
    .d   (main_d),
    .q   (main_q)
  );

  skid_data_reg #(.REG_SIZE(REG_SIZE)) u_skid (
    .clk (clk),
    .rst (rst),
    .en  (skid_en),
    .d   (up.data),
    .q   (skid_q)
  );

endmodule

// File: tb/tb_pipe_skid_reg.sv
// tb/tb_pipe_skid_reg.sv - randomized and directed checks of pipe_skid_reg against a queue model
module tb_pipe_skid_reg;

  logic       clk;
  logic       rst;
  logic       flush;
  logic [1:0] count;

  int checks;
  int failures;

  logic [31:0] mq[$];

  pipe_skid_reg_if #(.REG_SIZE(32)) up_if ();
  pipe_skid_reg_if #(.REG_SIZE(32)) dn_if ();

  pipe_skid_reg #(.REG_SIZE(32)) dut (
    .clk   (clk),
    .rst   (rst),
    .flush (flush),
    .up    (up_if),
    .dn    (dn_if),
    .count (count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Compare outputs mid-cycle against the queue, then advance the queue by the handshake rules.
  task automatic tick();
    bit ofire;
    bit ifire;
    @(negedge clk);
    check_eq("in_ready", 32'(up_if.ready), 32'(mq.size() < 2));
    check_eq("out_valid", 32'(dn_if.valid), 32'(mq.size() != 0));
    check_eq("count", 32'(count), 32'(mq.size()));
    check_eq("rdy_full", 32'(up_if.ready && count == 2'd2), 32'd0);
    if (mq.size() != 0)
      check_eq("out_data", dn_if.data, mq[0]);
    if (rst) begin
      mq.delete();
    end else if (flush) begin
      mq.delete();
    end else begin
      ofire = (mq.size() != 0) && dn_if.ready;
      ifire = (mq.size() < 2) && up_if.valid;
      if (ofire) void'(mq.pop_front());
      if (ifire) mq.push_back(up_if.data);
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    rst          = 1'b1;
    flush        = 1'b0;
    up_if.valid  = 1'b1;
    up_if.data   = 32'hDEADBEEF;
    dn_if.ready  = 1'b0;

    // Reset held with a word presented upstream.
    repeat (3) begin
      tick();
      check_eq("rst_data", dn_if.data, 32'd0);
      check_eq("rst_valid", 32'(dn_if.valid), 32'd0);
    end
    rst = 1'b0;
    tick();
    check_eq("first_capture", dn_if.data, 32'hDEADBEEF);
    check_eq("first_count", 32'(count), 32'd1);
    up_if.valid = 1'b0;
    dn_if.ready = 1'b1;
    tick();

    // Streaming at full rate: each word visible right after its edge, occupancy 1.
    for (int i = 1; i <= 4; i++) begin
      up_if.valid = 1'b1;
      up_if.data  = 32'(i);
      tick();
      check_eq("stream_data", dn_if.data, 32'(i));
      check_eq("stream_count", 32'(count), 32'd1);
    end
    up_if.valid = 1'b0;
    tick();

    // Stall: 10, 11 fill both entries; 12 must wait.
    dn_if.ready = 1'b0;
    up_if.valid = 1'b1;
    up_if.data  = 32'd10;
    tick();
    up_if.data  = 32'd11;
    tick();
    up_if.data  = 32'd12;
    tick();
    tick();
    check_eq("stall_count", 32'(count), 32'd2);
    check_eq("stall_ready", 32'(up_if.ready), 32'd0);
    check_eq("stall_data", dn_if.data, 32'd10);
    dn_if.ready = 1'b1;
    tick();
    check_eq("recover_ready", 32'(up_if.ready), 32'd1);
    check_eq("recover_data", dn_if.data, 32'd11);
    tick();
    up_if.valid = 1'b0;
    check_eq("recover_data2", dn_if.data, 32'd12);
    tick();
    tick();

    // Flush while full, with 22 offered in the same cycle.
    dn_if.ready = 1'b0;
    up_if.valid = 1'b1;
    up_if.data  = 32'd20;
    tick();
    up_if.data  = 32'd21;
    tick();
    up_if.data  = 32'd22;
    flush       = 1'b1;
    tick();
    flush       = 1'b0;
    up_if.valid = 1'b0;
    check_eq("flush_count", 32'(count), 32'd0);
    check_eq("flush_valid", 32'(dn_if.valid), 32'd0);
    dn_if.ready = 1'b1;
    tick();
    tick();

    // Asynchronous reset pulse between edges while holding 30.
    dn_if.ready = 1'b0;
    up_if.valid = 1'b1;
    up_if.data  = 32'd30;
    tick();
    up_if.valid = 1'b0;
    check_eq("hold30", dn_if.data, 32'd30);
    #1 rst = 1'b1;
    #1;
    check_eq("arst_valid", 32'(dn_if.valid), 32'd0);
    check_eq("arst_count", 32'(count), 32'd0);
    check_eq("arst_data", dn_if.data, 32'd0);
    rst = 1'b0;
    mq.delete();
    dn_if.ready = 1'b1;
    tick();
    tick();

    // Random traffic with occasional flush.
    for (int n = 0; n < 1000; n++) begin
      up_if.valid = 1'($urandom_range(0, 1));
      up_if.data  = $urandom;
      dn_if.ready = 1'($urandom_range(0, 1));
      flush       = ($urandom_range(0, 49) == 0);
      tick();
    end
    flush       = 1'b0;
    up_if.valid = 1'b0;
    dn_if.ready = 1'b1;
    repeat (3) tick();
    check_eq("drained", 32'(count), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/pipe_skid_reg.md
# pipe_skid_reg

Two-entry ready/valid pipeline register that sits between RISC-V pipeline stages. It takes words from the upstream stage and holds them until the downstream stage accepts them. It adds a one-word skid entry, so IN_READY is a registered decode and never depends combinationally on OUT_READY. Full throughput is one word per cycle with one cycle of latency.

## Interface
- REG_SIZE, default 32: width of the data path in bits.
- CLK  input  1  system clock; all state updates on posedge.
- RST  input  1  asynchronous reset, active-high.
- FLUSH  input  1  synchronous flush: discard all held words.
- IN_VALID  input  1  upstream presents IN_DATA.
- IN_READY  output  1  block can accept a word this cycle.
- IN_DATA  input  REG_SIZE  upstream word.
- OUT_VALID  output  1  OUT_DATA holds a valid word.
- OUT_READY  input  1  downstream accepts OUT_DATA this cycle.
- OUT_DATA  output  REG_SIZE  oldest held word.
- COUNT  output  2  number of words held (0..2).

## Operation
- in_fire = IN_VALID & IN_READY; out_fire = OUT_VALID & OUT_READY.
- Storage:
  - main register drives OUT_DATA;
  - skid register holds the second word.
- State register, with three states:
  - S_EMPTY (COUNT 0): OUT_VALID 0, IN_READY 1.
    - in_fire → main ← IN_DATA, go to S_BUSY.
  - S_BUSY (COUNT 1): OUT_VALID 1, IN_READY 1.
    - in_fire & out_fire → main ← IN_DATA, stay in S_BUSY.
    - in_fire only → skid ← IN_DATA, go to S_FULL.
    - out_fire only → go to S_EMPTY.
    - neither → hold.
  - S_FULL (COUNT 2): OUT_VALID 1, IN_READY 0.
    - out_fire → main ← skid, go to S_BUSY.
    - else hold.
    - IN_VALID is ignored.
- Outputs derived from the state register:
  - IN_READY, OUT_VALID and COUNT are pure decodes of the state register.
  - None of them has a combinational path from IN_VALID or OUT_READY.
- FLUSH:
  - next state S_EMPTY regardless of handshakes;
  - overrides in_fire in the same cycle, so that word is dropped;
  - data registers are not written.
- Ordering: words leave in arrival order. No word is duplicated or lost except by FLUSH.
- Data is never modified; width in equals width out, REG_SIZE bits.
- Illegal state encoding (2'd3) → S_EMPTY on next clock.

## Timing
- RST asserted, effective immediately (asynchronous):
  - state S_EMPTY;
  - main and skid registers = 0, so OUT_DATA = 0;
  - OUT_VALID 0, IN_READY 1, COUNT 0.
- RST mid-transfer: any held words are lost and no out_fire is reported afterwards. The first edge after deassertion behaves as S_EMPTY.
- Latency: a word accepted at edge N appears on OUT_DATA, with OUT_VALID 1, right after edge N.
- Throughput: one word per cycle in S_BUSY when both sides fire every cycle. The skid entry is used only after OUT_READY drops.
- Stall recovery: after S_FULL, the first out_fire returns to S_BUSY, and IN_READY is 1 again in the following cycle.
- OUT_DATA and OUT_VALID stay stable while OUT_VALID=1 and OUT_READY=0.
- FLUSH and RST are independent; RST wins.

## Structure
- Shared package pipe_pkg contains:
  - typedef enum logic [1:0] skid_state_t with S_EMPTY=2'd0, S_BUSY=2'd1, S_FULL=2'd2;
  - constant SKID_DEPTH = 2.
- Sub-module skid_data_reg: REG_SIZE-wide enable-loaded register with asynchronous active-high reset to 0. It is instantiated twice, once as main and once as skid.
  - The main register uses a 2:1 mux on its D input, selecting IN_DATA or skid.
- The top level holds the FSM, enable decode and output decode.

## Test plan
- Reset: hold RST with IN_VALID=1 and IN_DATA=32'hDEADBEEF.
  - Required: OUT_VALID=0, IN_READY=1, COUNT=0, OUT_DATA=0 throughout.
  - Required: first edge after deassertion captures 32'hDEADBEEF.
- Streaming: OUT_READY=1 constantly; send 1,2,3,4 on consecutive cycles.
  - Required: OUT_DATA shows 1,2,3,4 one cycle later, with no bubbles.
  - Required: COUNT stays 1 during the stream.
- Stall/skid: send 10 then 11 while OUT_READY=0.
  - Required: COUNT=2, IN_READY=0, and 12 is held off upstream.
  - Then raise OUT_READY. Required: outputs 10, 11, 12 in order; IN_READY returns to 1 one cycle after the first accept.
- Flush: in S_FULL holding 20, 21, assert FLUSH together with IN_VALID carrying 22.
  - Required: next cycle COUNT=0, OUT_VALID=0, and 22 is never output.
- Async reset mid-operation: in S_BUSY holding 30, pulse RST between clock edges.
  - Required: OUT_VALID drops before the next edge and 30 is never delivered.
- Random backpressure: 1000 cycles of random IN_VALID and OUT_READY, checked against a scoreboard queue.
  - Required: in-order, lossless delivery.
  - Required: IN_READY is never 1 while COUNT=2.
